// File: rtl/priv_1_11_trap_sequencer.sv
// priv_1_11_trap_sequencer: trap/mret sequencer for the 1.11 privilege unit
// Latches pending interrupts, arbitrates trap causes, then emits CSR strobes and a pipeline redirect.
module priv_1_11_trap_sequencer #(
  parameter int NINT = 12,
  parameter int NEXC = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NEXC-1:0] exc_vec,
  input  logic [NINT-1:0] int_set,
  input  logic [NINT-1:0] int_clr,
  input  logic [NINT-1:0] mie,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [31:0]     mtvec,
  input  logic [31:0]     mepc,
  input  logic [31:0]     epc,
  input  logic [31:0]     mtval,
  input  logic            pipe_clear,
  input  logic            mret,
  output logic            mip_rup,
  output logic [NINT-1:0] mip_next,
  output logic            mcause_rup,
  output logic            mepc_rup,
  output logic            mtval_rup,
  output logic            mstatus_rup,
  output logic [31:0]     mcause_next,
  output logic [31:0]     mepc_next,
  output logic [31:0]     mtval_next,
  output logic            mstatus_mie_next,
  output logic            mstatus_mpie_next,
  output logic            intr,
  output logic            insert_pc,
  output logic [31:0]     priv_pc
);
  typedef enum logic [2:0] {IDLE, WAIT_CLEAR, COMMIT, REDIRECT, MRET} state_t;
  // index 0 is the highest priority
  localparam logic [4:0] EXC_PRI [14] = '{5'd3, 5'd12, 5'd1, 5'd2, 5'd0, 5'd11, 5'd9,
                                          5'd8, 5'd6, 5'd4, 5'd15, 5'd13, 5'd7, 5'd5};
  localparam logic [4:0] INT_PRI [9] = '{5'd11, 5'd3, 5'd7, 5'd9, 5'd1, 5'd5, 5'd8, 5'd0, 5'd4};
  state_t          r_state;
  logic [NINT-1:0] r_mip;
  logic [4:0]      r_code;
  logic            r_intr;
  logic [31:0]     r_epc, r_mtval;
  logic            r_csr_rup, r_mstatus_rup, r_insert_pc, r_mie_nx, r_mpie_nx;
  logic [31:0]     r_mcause_nx, r_mepc_nx, r_mtval_nx, r_priv_pc;
  logic [NINT-1:0] w_mip_nx;
  logic [31:0]     w_exc, w_pend;
  logic            w_ehit, w_ihit;
  logic [4:0]      w_ecode, w_icode;
  assign w_mip_nx = (r_mip & ~int_clr) | int_set;
  assign w_exc    = 32'(exc_vec);
  assign w_pend   = 32'(r_mip & mie & {NINT{mstatus_mie}});
  // walk from lowest to highest priority so the highest hit is written last
  always_comb begin
    w_ehit  = 1'b0;
    w_ecode = 5'd0;
    w_ihit  = 1'b0;
    w_icode = 5'd0;
    for (int k = 13; k >= 0; k--)
      if (w_exc[EXC_PRI[k]]) begin
        w_ehit  = 1'b1;
        w_ecode = EXC_PRI[k];
      end
    for (int k = 8; k >= 0; k--)
      if (w_pend[INT_PRI[k]]) begin
        w_ihit  = 1'b1;
        w_icode = INT_PRI[k];
      end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_mip         <= '0;
      r_code        <= '0;
      r_intr        <= 1'b0;
      r_epc         <= '0;
      r_mtval       <= '0;
      r_csr_rup     <= 1'b0;
      r_mstatus_rup <= 1'b0;
      r_insert_pc   <= 1'b0;
      r_mie_nx      <= 1'b0;
      r_mpie_nx     <= 1'b0;
      r_mcause_nx   <= '0;
      r_mepc_nx     <= '0;
      r_mtval_nx    <= '0;
      r_priv_pc     <= '0;
    end else begin
      r_mip         <= w_mip_nx;
      r_csr_rup     <= 1'b0;
      r_mstatus_rup <= 1'b0;
      r_insert_pc   <= 1'b0;
      case (r_state)
        IDLE:
          if (w_ehit || w_ihit) begin
            r_state <= WAIT_CLEAR;
            r_code  <= w_ehit ? w_ecode : w_icode;
            r_intr  <= !w_ehit;
            r_epc   <= epc;
            r_mtval <= w_ehit ? mtval : 32'd0;
          end else if (mret) begin
            r_state       <= MRET;
            r_insert_pc   <= 1'b1;
            r_priv_pc     <= mepc;
            r_mstatus_rup <= 1'b1;
            r_mie_nx      <= mstatus_mpie;
            r_mpie_nx     <= 1'b1;
          end
        WAIT_CLEAR:
          if (pipe_clear) begin
            r_state       <= COMMIT;
            r_csr_rup     <= 1'b1;
            r_mstatus_rup <= 1'b1;
            r_mcause_nx   <= {r_intr, 26'd0, r_code};
            r_mepc_nx     <= r_epc;
            r_mtval_nx    <= r_mtval;
            r_mpie_nx     <= mstatus_mie;
            r_mie_nx      <= 1'b0;
          end
        COMMIT: begin
          r_state     <= REDIRECT;
          r_insert_pc <= 1'b1;
          r_priv_pc   <= {mtvec[31:2], 2'b00} +
                         ((mtvec[1:0] == 2'b01 && r_intr) ? {25'd0, r_code, 2'b00} : 32'd0);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mip_rup           = nRST && (w_mip_nx != r_mip);
  assign mip_next          = mip_rup ? w_mip_nx : r_mip;
  assign mcause_rup        = r_csr_rup;
  assign mepc_rup          = r_csr_rup;
  assign mtval_rup         = r_csr_rup;
  assign mstatus_rup       = r_mstatus_rup;
  assign mcause_next       = r_mcause_nx;
  assign mepc_next         = r_mepc_nx;
  assign mtval_next        = r_mtval_nx;
  assign mstatus_mie_next  = r_mie_nx;
  assign mstatus_mpie_next = r_mpie_nx;
  assign intr              = r_intr;
  assign insert_pc         = r_insert_pc;
  assign priv_pc           = r_priv_pc;
endmodule
